// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents: opcode constants, the controller state encoding, and the register read/write decode helpers.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_BNE = 6'h05;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_t;

  function automatic logic reads_regs(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_BNE);
  endfunction

  function automatic logic writes_reg(input logic [5:0] op, input logic [4:0] rd);
    return (op == OP_ADD) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundles the ID-stage instruction fields and the pipeline enable outputs of the hazard controller.
// The counter outputs are present only when PIPE_HAZARD_STATS_EN is defined.
interface pipe_hazard_ctrl_if;

  logic       ID_VALID;
  logic [5:0] ID_OP;
  logic [4:0] ID_RS;
  logic [4:0] ID_RT;
  logic [4:0] ID_RD;
  logic       EX_TKN;
  logic       PC_WE;
  logic       IFID_WE;
  logic       IFID_FLUSH;
  logic       IDEX_BUBBLE;
  logic [1:0] STATE;

`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] STALL_CNT;
  logic [31:0] FLUSH_CNT;
  logic [31:0] ISSUE_CNT;

  modport master (
    output ID_VALID, ID_OP, ID_RS, ID_RT, ID_RD, EX_TKN,
    input  PC_WE, IFID_WE, IFID_FLUSH, IDEX_BUBBLE, STATE,
    input  STALL_CNT, FLUSH_CNT, ISSUE_CNT
  );

  modport slave (
    input  ID_VALID, ID_OP, ID_RS, ID_RT, ID_RD, EX_TKN,
    output PC_WE, IFID_WE, IFID_FLUSH, IDEX_BUBBLE, STATE,
    output STALL_CNT, FLUSH_CNT, ISSUE_CNT
  );
`else
  modport master (
    output ID_VALID, ID_OP, ID_RS, ID_RT, ID_RD, EX_TKN,
    input  PC_WE, IFID_WE, IFID_FLUSH, IDEX_BUBBLE, STATE
  );

  modport slave (
    input  ID_VALID, ID_OP, ID_RS, ID_RT, ID_RD, EX_TKN,
    output PC_WE, IFID_WE, IFID_FLUSH, IDEX_BUBBLE, STATE
  );
`endif

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Per-register busy scoreboard: a 2-bit down-counter per register, loaded on writer issue.
// Provides two busy read ports (rs, rt). Register 0 is never busy.
module hazard_scoreboard #(
  parameter int WB_LAT = 1,
  parameter int NREG   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_we,
  input  logic [4:0] issue_rd,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       busy_rs,
  output logic       busy_rt
);

  localparam logic [1:0] LOAD = 2'(WB_LAT);

  logic [1:0]  cnt [NREG];
  logic [31:0] busy;

  // A reload on issue takes precedence over the decrement of the same register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst || i == 0) begin
        cnt[i] <= 2'd0;
      end else if (issue_we && issue_rd == 5'(i)) begin
        cnt[i] <= LOAD;
      end else if (cnt[i] != 2'd0) begin
        cnt[i] <= cnt[i] - 2'd1;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 1; i < NREG && i < 32; i++) begin
      busy[i] = (cnt[i] != 2'd0);
    end
  end

  assign busy_rs = busy[rs];
  assign busy_rt = busy[rt];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock and flush controller for the four-stage ADD/BNE pipeline.
// Defining PIPE_HAZARD_STATS_EN adds saturating stall/flush/issue counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WB_LAT = 1,
  parameter int NREG   = 32
) (
  input logic               CLK,
  input logic               RST,
  pipe_hazard_ctrl_if.slave bus
);

  logic        busy_rs;
  logic        busy_rt;
  logic        hz;
  logic        flush;
  logic        issue;
  logic        issue_we;
  ctrl_state_t state;

  assign hz       = bus.ID_VALID && reads_regs(bus.ID_OP) && (busy_rs || busy_rt);
  assign flush    = bus.EX_TKN;
  assign issue    = bus.ID_VALID && !hz && !flush && !RST;
  assign issue_we = issue && writes_reg(bus.ID_OP, bus.ID_RD);

  hazard_scoreboard #(
    .WB_LAT (WB_LAT),
    .NREG   (NREG)
  ) u_scoreboard (
    .clk      (CLK),
    .rst      (RST),
    .issue_we (issue_we),
    .issue_rd (bus.ID_RD),
    .rs       (bus.ID_RS),
    .rt       (bus.ID_RT),
    .busy_rs  (busy_rs),
    .busy_rt  (busy_rt)
  );

  // A taken branch overrides a stall; reset forces free-running enables.
  always_comb begin
    bus.PC_WE       = 1'b1;
    bus.IFID_WE     = 1'b1;
    bus.IFID_FLUSH  = 1'b0;
    bus.IDEX_BUBBLE = 1'b0;
    if (!RST) begin
      if (flush) begin
        bus.IFID_FLUSH  = 1'b1;
        bus.IDEX_BUBBLE = 1'b1;
      end else if (hz) begin
        bus.PC_WE       = 1'b0;
        bus.IFID_WE     = 1'b0;
        bus.IDEX_BUBBLE = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_RUN;
    end else if (flush) begin
      state <= ST_FLUSH;
    end else if (hz) begin
      state <= ST_STALL;
    end else begin
      state <= ST_RUN;
    end
  end

  assign bus.STATE = state;

`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] issue_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (hz && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (flush && flush_cnt != '1)        flush_cnt <= flush_cnt + 32'd1;
      if (issue && issue_cnt != '1)        issue_cnt <= issue_cnt + 32'd1;
    end
  end

  assign bus.STALL_CNT = stall_cnt;
  assign bus.FLUSH_CNT = flush_cnt;
  assign bus.ISSUE_CNT = issue_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a per-cycle vector table on a WB_LAT=1 instance, plus hand
// sequences for the unpadded loop and the WB_LAT=2 stall and reset corners.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct {
    logic       rst;
    logic       valid;
    logic       tkn;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       pc_we;
    logic       ifid_we;
    logic       ifid_flush;
    logic       idex_bubble;
    logic [1:0] state;
  } vec_t;

  localparam logic [5:0] ADD = OP_ADD;
  localparam logic [5:0] BNE = OP_BNE;
  localparam logic [5:0] OTH = 6'h23;
  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] STL = 2'd1;
  localparam logic [1:0] FLS = 2'd2;

  logic CLK = 1'b0;
  logic RST;
  int   compared   = 0;
  int   mismatched = 0;
  vec_t vecs[$];

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl_if bus1 ();
  pipe_hazard_ctrl_if bus2 ();

  assign bus2.ID_VALID = bus1.ID_VALID;
  assign bus2.ID_OP    = bus1.ID_OP;
  assign bus2.ID_RS    = bus1.ID_RS;
  assign bus2.ID_RT    = bus1.ID_RT;
  assign bus2.ID_RD    = bus1.ID_RD;
  assign bus2.EX_TKN   = bus1.EX_TKN;

  pipe_hazard_ctrl #(.WB_LAT(1), .NREG(32)) dut  (.CLK(CLK), .RST(RST), .bus(bus1));
  pipe_hazard_ctrl #(.WB_LAT(2), .NREG(32)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

  function automatic vec_t mk(input logic rst, input logic valid, input logic tkn,
                              input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic pc, input logic ifid,
                              input logic fl, input logic bub, input logic [1:0] st);
    vec_t v;
    v.rst = rst; v.valid = valid; v.tkn = tkn; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd;
    v.pc_we = pc; v.ifid_we = ifid; v.ifid_flush = fl; v.idex_bubble = bub; v.state = st;
    return v;
  endfunction

  function automatic vec_t runV(input logic rst, input logic valid, input logic tkn, input logic [5:0] op,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [1:0] st);
    return mk(rst, valid, tkn, op, rs, rt, rd, 1'b1, 1'b1, 1'b0, 1'b0, st);
  endfunction

  function automatic vec_t stallV(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [1:0] st);
    return mk(1'b0, 1'b1, 1'b0, op, rs, rt, rd, 1'b0, 1'b0, 1'b0, 1'b1, st);
  endfunction

  function automatic vec_t flushV(input logic valid, input logic [5:0] op, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd, input logic [1:0] st);
    return mk(1'b0, valid, 1'b1, op, rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b1, st);
  endfunction

  task automatic checkVal(input string what, input int idx, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", what, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    RST           = v.rst;
    bus1.ID_VALID = v.valid;
    bus1.EX_TKN   = v.tkn;
    bus1.ID_OP    = v.op;
    bus1.ID_RS    = v.rs;
    bus1.ID_RT    = v.rt;
    bus1.ID_RD    = v.rd;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    @(negedge CLK);
    checkVal("PC_WE",       idx, 32'(bus1.PC_WE),       32'(v.pc_we));
    checkVal("IFID_WE",     idx, 32'(bus1.IFID_WE),     32'(v.ifid_we));
    checkVal("IFID_FLUSH",  idx, 32'(bus1.IFID_FLUSH),  32'(v.ifid_flush));
    checkVal("IDEX_BUBBLE", idx, 32'(bus1.IDEX_BUBBLE), 32'(v.idex_bubble));
    checkVal("STATE",       idx, 32'(bus1.STATE),       32'(v.state));
    @(posedge CLK);
    #1;
  endtask

  task automatic checkLat2(input vec_t v, input logic pc, input logic [1:0] st, input int idx);
    applyStimulus(v);
    @(negedge CLK);
    checkVal("LAT2.PC_WE", idx, 32'(bus2.PC_WE), 32'(pc));
    checkVal("LAT2.STATE", idx, 32'(bus2.STATE), 32'(st));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    applyStimulus(runV(1'b1, 1'b0, 1'b0, ADD, 5'd0, 5'd0, 5'd0, RUN));
    repeat (2) @(posedge CLK);
    #1;

    // Each row is one clock cycle; STATE is the value registered at the previous edge.
    vecs.push_back(runV(1'b1, 1'b1, 1'b1, ADD, 5'd5, 5'd1, 5'd5, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, ADD, 5'd5, 5'd1, 5'd5, RUN));
    vecs.push_back(stallV(BNE, 5'd4, 5'd5, 5'd0, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, BNE, 5'd4, 5'd5, 5'd0, STL));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, ADD, 5'd0, 5'd1, 5'd6, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, ADD, 5'd2, 5'd3, 5'd7, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, BNE, 5'd6, 5'd6, 5'd0, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, ADD, 5'd0, 5'd0, 5'd0, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, BNE, 5'd0, 5'd0, 5'd0, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, ADD, 5'd1, 5'd1, 5'd8, RUN));
    vecs.push_back(flushV(1'b1, BNE, 5'd8, 5'd8, 5'd0, RUN));
    vecs.push_back(runV(1'b0, 1'b0, 1'b0, ADD, 5'd0, 5'd0, 5'd0, FLS));
    vecs.push_back(flushV(1'b1, ADD, 5'd1, 5'd1, 5'd9, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, BNE, 5'd9, 5'd9, 5'd0, FLS));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, ADD, 5'd1, 5'd1, 5'd10, RUN));
    vecs.push_back(stallV(BNE, 5'd10, 5'd10, 5'd0, RUN));
    vecs.push_back(runV(1'b1, 1'b1, 1'b0, BNE, 5'd10, 5'd10, 5'd0, STL));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, BNE, 5'd10, 5'd10, 5'd0, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, ADD, 5'd1, 5'd1, 5'd11, RUN));
    vecs.push_back(runV(1'b0, 1'b0, 1'b0, BNE, 5'd11, 5'd11, 5'd0, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, ADD, 5'd1, 5'd1, 5'd12, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, OTH, 5'd12, 5'd12, 5'd0, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, ADD, 5'd1, 5'd1, 5'd13, RUN));
    vecs.push_back(stallV(BNE, 5'd13, 5'd0, 5'd0, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, BNE, 5'd13, 5'd0, 5'd0, STL));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, BNE, 5'd1, 5'd2, 5'd14, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, ADD, 5'd14, 5'd14, 5'd15, RUN));
    vecs.push_back(stallV(ADD, 5'd15, 5'd0, 5'd15, RUN));
    vecs.push_back(runV(1'b0, 1'b1, 1'b0, ADD, 5'd15, 5'd0, 5'd15, STL));
    vecs.push_back(stallV(ADD, 5'd15, 5'd0, 5'd16, RUN));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Unpadded loop: add $5,$5,$1 ; bne $4,$5,L1 taken three times, then falls through.
    applyStimulus(runV(1'b1, 1'b0, 1'b0, ADD, 5'd0, 5'd0, 5'd0, STL));
    checkOutput(runV(1'b1, 1'b0, 1'b0, ADD, 5'd0, 5'd0, 5'd0, STL), 100);
    for (int k = 0; k < 4; k++) begin
      vec_t a, b, c, d, e;
      a = runV(1'b0, 1'b1, 1'b0, ADD, 5'd5, 5'd1, 5'd5, RUN);
      b = stallV(BNE, 5'd4, 5'd5, 5'd0, RUN);
      c = runV(1'b0, 1'b1, 1'b0, BNE, 5'd4, 5'd5, 5'd0, STL);
      d = flushV(1'b1, ADD, 5'd6, 5'd6, 5'd6, RUN);
      e = runV(1'b0, 1'b0, 1'b0, ADD, 5'd0, 5'd0, 5'd0, FLS);
      applyStimulus(a); checkOutput(a, 110 + 10 * k);
      applyStimulus(b); checkOutput(b, 111 + 10 * k);
      applyStimulus(c); checkOutput(c, 112 + 10 * k);
      if (k < 3) begin
        applyStimulus(d); checkOutput(d, 113 + 10 * k);
        applyStimulus(e); checkOutput(e, 114 + 10 * k);
      end
    end
    applyStimulus(runV(1'b0, 1'b0, 1'b0, ADD, 5'd0, 5'd0, 5'd0, RUN));
    @(negedge CLK);
    checkVal("LOOP.STATE", 150, 32'(bus1.STATE), 32'(RUN));
`ifdef PIPE_HAZARD_STATS_EN
    checkVal("STALL_CNT", 150, bus1.STALL_CNT, 32'd4);
    checkVal("FLUSH_CNT", 150, bus1.FLUSH_CNT, 32'd3);
    checkVal("ISSUE_CNT", 150, bus1.ISSUE_CNT, 32'd8);
`endif
    @(posedge CLK);
    #1;

    // WB_LAT=2 instance: two-cycle stall, one-cycle stall with a spacer, reset abandoning a stall.
    checkLat2(runV(1'b1, 1'b0, 1'b0, ADD, 5'd0, 5'd0, 5'd0, RUN), 1'b1, RUN, 200);
    checkLat2(runV(1'b0, 1'b1, 1'b0, ADD, 5'd5, 5'd1, 5'd5, RUN), 1'b1, RUN, 201);
    checkLat2(runV(1'b0, 1'b1, 1'b0, BNE, 5'd4, 5'd5, 5'd0, RUN), 1'b0, RUN, 202);
    checkLat2(runV(1'b0, 1'b1, 1'b0, BNE, 5'd4, 5'd5, 5'd0, RUN), 1'b0, STL, 203);
    checkLat2(runV(1'b0, 1'b1, 1'b0, BNE, 5'd4, 5'd5, 5'd0, RUN), 1'b1, STL, 204);
    checkLat2(runV(1'b0, 1'b1, 1'b0, ADD, 5'd5, 5'd1, 5'd5, RUN), 1'b1, RUN, 205);
    checkLat2(runV(1'b0, 1'b1, 1'b0, ADD, 5'd2, 5'd3, 5'd7, RUN), 1'b1, RUN, 206);
    checkLat2(runV(1'b0, 1'b1, 1'b0, BNE, 5'd4, 5'd5, 5'd0, RUN), 1'b0, RUN, 207);
    checkLat2(runV(1'b0, 1'b1, 1'b0, BNE, 5'd4, 5'd5, 5'd0, RUN), 1'b1, STL, 208);
    checkLat2(runV(1'b0, 1'b1, 1'b0, ADD, 5'd1, 5'd1, 5'd10, RUN), 1'b1, RUN, 209);
    checkLat2(runV(1'b0, 1'b1, 1'b0, BNE, 5'd10, 5'd10, 5'd0, RUN), 1'b0, RUN, 210);
    checkLat2(runV(1'b1, 1'b1, 1'b0, BNE, 5'd10, 5'd10, 5'd0, RUN), 1'b1, STL, 211);
    checkLat2(runV(1'b0, 1'b1, 1'b0, BNE, 5'd10, 5'd10, 5'd0, RUN), 1'b1, RUN, 212);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Interlock and flush controller for the four-stage ADD/BNE pipeline (IF, ID, EX, WB), which has no data forwarding. It tracks register writes in flight in a per-register scoreboard and stalls IF/ID while an ID-stage source is still pending. On a taken branch it squashes the two wrong-path instructions. This removes the hand-inserted NOP padding from programs; the block sits beside the datapath and drives its PC, IF/ID and ID/EX enables.

## Interface
- `WB_LAT`, default 1: cycles after issue during which a destination stays busy. Range 1..3. A value of 1 matches the negedge register-file write in WB.
- `NREG`, default 32: number of architectural registers. Register 0 is never busy.

Ports:
- `CLK  in  1`: clock, rising edge.
- `RST  in  1`: reset, synchronous, active-high.
- `ID_VALID  in  1`: IF/ID holds a real instruction.
- `ID_OP  in  6`: opcode of the IF/ID instruction.
- `ID_RS  in  5`: rs field of the IF/ID instruction.
- `ID_RT  in  5`: rt field of the IF/ID instruction.
- `ID_RD  in  5`: rd field of the IF/ID instruction.
- `EX_TKN  in  1`: branch in EX is taken.
- `PC_WE  out  1`: PC load enable.
- `IFID_WE  out  1`: IF/ID load enable.
- `IFID_FLUSH  out  1`: load zero (NOP) into IF/ID.
- `IDEX_BUBBLE  out  1`: load NOP (OP=0, RD=0) into ID/EX.
- `STATE  out  2`: 0 = RUN, 1 = STALL, 2 = FLUSH.

## Operation
- Readers: OP 0x00 (ADD) and OP 0x05 (BNE) read RS and RT. Other opcodes read nothing.
- Writers: only OP 0x00 with RD != 0 writes.
- Scoreboard: one 2-bit down-counter per register.
  - Issue means ID_VALID=1, no stall and no flush at the edge.
  - On issue of a writer, set `cnt[RD] = WB_LAT`.
  - Every other nonzero counter decrements each cycle.
  - A register is busy while its counter is nonzero.
- Hazard: `HZ = ID_VALID & reader & (busy[RS] | busy[RT])`. Register 0 is never busy.
- Output priority:
  - EX_TKN: PC_WE=1, IFID_WE=1, IFID_FLUSH=1, IDEX_BUBBLE=1. No issue occurs that cycle, even if HZ=1.
  - Else HZ: PC_WE=0, IFID_WE=0, IDEX_BUBBLE=1, IFID_FLUSH=0.
  - Else: PC_WE=1, IFID_WE=1, IFID_FLUSH=0, IDEX_BUBBLE=0.
- FSM, registered, next state chosen with the same priority: EX_TKN → FLUSH, else HZ → STALL, else RUN. FLUSH lasts exactly one cycle unless EX_TKN reasserts. A bubble reaching EX always has EX_TKN=0, so no back-to-back flush occurs from one branch.
- Branch after writer: a BNE that depends on the immediately preceding ADD stalls WB_LAT cycles in ID, then issues normally.
- A squashed writer in ID never enters the scoreboard.

## Timing
- Outputs are combinational from the scoreboard, FSM state and inputs. Settle by mid-cycle.
- Reset (RST=1 at an edge): all counters go to 0 and STATE goes to RUN. While RST=1, PC_WE=1, IFID_WE=1, IFID_FLUSH=0, IDEX_BUBBLE=0. Reset mid-stall abandons the stall immediately.
- Stall length for a dependent pair is exactly WB_LAT cycles minus the number of independent instructions between them, floored at 0.
- Taken-branch penalty is exactly 2 cycles: the IF/ID and ID/EX contents at EX_TKN are squashed.
- Writer issue and decrement of the same register in one cycle: issue wins, counter reloads to WB_LAT.
- Counters saturate at 0 and never wrap.

## Configuration
- `PIPE_HAZARD_STATS_EN` defined:
  - Adds outputs `STALL_CNT out 32`, `FLUSH_CNT out 32` and `ISSUE_CNT out 32`.
  - Each increments on a cycle with HZ-stall, flush, or issue respectively.
  - Each saturates at 0xFFFFFFFF and clears on RST.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - opcode constants `OP_ADD=6'h00` and `OP_BNE=6'h05`
  - the state encoding `ST_RUN`, `ST_STALL`, `ST_FLUSH`
  - the reader and writer decode functions
- One sub-module, `hazard_scoreboard`. It holds the NREG counter array, with an issue/RD write port and two busy read ports (RS, RT).
- The FSM, priority logic and stats counters live in `pipe_hazard_ctrl`.

## Test plan
- Back-to-back dependency (WB_LAT=1): `add $5,$5,$1` then `bne $4,$5,L1` with r1=1, r4=4, r5=0. Expect one STALL cycle (PC_WE=0, IDEX_BUBBLE=1), and the BNE sees RRT=1.
- One independent instruction between writer and reader: no stall, and STATE stays RUN.
- Unpadded loop `L1: add $5,$5,$1; bne $4,$5,L1`: branch is taken 3 times, each time IFID_FLUSH=IDEX_BUBBLE=1 for exactly one cycle. Exit with r5=4, and with stats on, FLUSH_CNT=3 and STALL_CNT=4.
- EX_TKN asserted while ID holds a hazarding reader: flush wins, PC_WE=1, and no scoreboard entry is created for the squashed instruction.
- `add $0,$0,$0` (NOP) followed by a reader of $0: never stalls.
- Assert RST during STALL: the next cycle reports STATE=RUN, all busy bits are clear, and PC_WE=1.
